asu_sequencer: RTL and testbench

Bit-serial operation sequencer for the accumulator subtract datapath. It accepts one accumulator instruction at a time (NOP, LDN, SUB, STO) and runs it over one word of digit times. For each digit it generates the digit pulse (DPG) and the beat-start pulse (XTB) that clears the serial borrow. It also drives the accumulator load, zero-force and store-write enables around the subtract unit. It sits between the control unit (instruction decode) and the accumulator/ASU datapath.

---
 rtl/asu_sequencer_pkg.sv | 29 ++
 rtl/asu_sequencer_digit_timer.sv | 57 +++++
 rtl/asu_sequencer.sv | 132 +++++++++++++
 tb/tb_asu_sequencer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/asu_sequencer_pkg.sv
// Shared types and constants for the accumulator-subtract sequencer.
// The instruction and FSM encodings live here so that the top, the timer
// and any checker bound to them all agree on the same values.
package asu_seq_pkg;

  // Number of digit times in one accumulator word.
  localparam int DEF_WORD_BITS = 32;

  // Accumulator instruction codes, as delivered by instruction decode.
  typedef enum logic [1:0] {
    OP_NOP = 2'b00,
    OP_LDN = 2'b01,
    OP_SUB = 2'b10,
    OP_STO = 2'b11
  } op_t;

  // Sequencer states; also exported on the debug state port.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // True for instructions whose result is written back into A.
  function automatic logic op_loads_acc(op_t o);
    return (o == OP_LDN) || (o == OP_SUB);
  endfunction

endpackage

// File: rtl/asu_sequencer_digit_timer.sv
// Digit timer: a cycle-within-digit counter and a digit counter.
// The cycle counter runs 0..DIGIT_CYCLES-1 while enable is high. Each time
// it wraps, digit steps forward. After the last cycle of the last digit,
// digit returns to 0, which is the only way the digit index wraps.
// clear (start accepted) and rst both force the counters to zero.
module digit_timer
  import asu_seq_pkg::*;
#(
  parameter int WORD_BITS    = DEF_WORD_BITS,
  parameter int DIGIT_CYCLES = 1,
  parameter int DW           = $clog2(WORD_BITS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          enable,
  output logic [DW-1:0] digit,
  output logic          first_cycle,
  output logic          first_digit,
  output logic          last_digit_last_cycle
);

  // Keep the cycle counter at least one bit wide so DIGIT_CYCLES=1 is legal.
  localparam int CNT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [DW-1:0]    DIG_LAST = DW'(WORD_BITS - 1);

  logic [CNT_W-1:0] cnt;
  logic             cnt_wrap;

  assign cnt_wrap = (cnt == CNT_LAST);

  // Advance the cycle counter and, on its wrap, the digit counter.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt   <= '0;
      digit <= '0;
    end else if (enable) begin
      if (cnt_wrap) begin
        cnt <= '0;
        if (digit == DIG_LAST) begin
          digit <= '0;
        end else begin
          digit <= digit + DW'(1);
        end
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Timing markers are only meaningful on an enabled clock.
  assign first_cycle           = enable && (cnt == '0);
  assign first_digit           = (digit == '0);
  assign last_digit_last_cycle = enable && cnt_wrap && (digit == DIG_LAST);

endmodule

// File: rtl/asu_sequencer.sv
// asu_sequencer: runs one accumulator instruction (NOP/LDN/SUB/STO) over one
// word of digit times. It generates the digit pulse w_DPG and the beat-start
// pulse w_XTB that clears the serial borrow. It also drives the A-load,
// minuend zero-force and store-write enables.
//
// Optional feature macro: ASU_SEQ_STEP_EN. When it is defined, a step input
// is added, and RUN only advances on clocks where step=1. Between steps all
// outputs hold and the pulses are suppressed. This is the single-step mode
// used for button-driven bring-up.
//
// Handshake: ready=1 marks IDLE. A start sampled on a clock edge with
// ready=1 is accepted, and op is captured on that same edge. start at any
// other time (RUN, DONE, or with rst high) is dropped and never queued.
// done is a one-cycle completion pulse, and ready returns on the next cycle.
module asu_sequencer
  import asu_seq_pkg::*;
#(
  parameter int WORD_BITS    = DEF_WORD_BITS,
  parameter int DIGIT_CYCLES = 1,
  parameter int DW           = $clog2(WORD_BITS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
`ifdef ASU_SEQ_STEP_EN
  input  logic          step,
`endif
  input  logic [1:0]    op,
  output logic          ready,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] digit,
  output logic          w_DPG,
  output logic          w_XTB,
  output logic          a_load,
  output logic          a_zero,
  output logic          s_write,
  output logic [1:0]    dbg_state
);

  state_t state;
  op_t    op_q;
  op_t    op_in;
  logic   accept;
  logic   run_en;
  logic   first_cycle;
  logic   first_digit;
  logic   last_tick;

  assign op_in  = op_t'(op);
  assign accept = (state == ST_IDLE) && start;

`ifdef ASU_SEQ_STEP_EN
  assign run_en = (state == ST_RUN) && step;
`else
  assign run_en = (state == ST_RUN);
`endif

  digit_timer #(
    .WORD_BITS   (WORD_BITS),
    .DIGIT_CYCLES(DIGIT_CYCLES),
    .DW          (DW)
  ) u_timer (
    .clk                  (clk),
    .rst                  (rst),
    .clear                (accept),
    .enable               (run_en),
    .digit                (digit),
    .first_cycle          (first_cycle),
    .first_digit          (first_digit),
    .last_digit_last_cycle(last_tick)
  );

  // Sequencer FSM with registered status and datapath enables.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      op_q    <= OP_NOP;
      ready   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      a_load  <= 1'b0;
      a_zero  <= 1'b0;
      s_write <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            // Enables come from the incoming op so they are valid on the first RUN cycle.
            state   <= ST_RUN;
            op_q    <= op_in;
            ready   <= 1'b0;
            busy    <= 1'b1;
            a_load  <= op_loads_acc(op_in);
            a_zero  <= (op_in == OP_LDN);
            s_write <= (op_in == OP_STO);
          end
        end
        ST_RUN: begin
          if (last_tick) begin
            state   <= ST_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            a_load  <= 1'b0;
            a_zero  <= 1'b0;
            s_write <= 1'b0;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
          ready <= 1'b1;
        end
        default: begin
          state   <= ST_IDLE;
          ready   <= 1'b1;
          busy    <= 1'b0;
          done    <= 1'b0;
          a_load  <= 1'b0;
          a_zero  <= 1'b0;
          s_write <= 1'b0;
        end
      endcase
    end
  end

  // The digit pulse marks the first enabled cycle of each digit. The beat start marks digit 0 only.
  assign w_DPG     = first_cycle;
  assign w_XTB     = first_cycle && first_digit;
  assign dbg_state = state;

endmodule

// File: tb/tb_asu_sequencer.sv
// Testbench for asu_sequencer. It uses a default instance (WORD_BITS=32,
// DIGIT_CYCLES=1) and a second instance with DIGIT_CYCLES=3. A table of
// cycle vectors covers reset and the start of an LDN operation. Hand-written
// sequences cover the long multi-cycle cases.
module tb_asu_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance signals
  logic       rst, start;
  logic [1:0] op;
  logic       ready, busy, done, w_DPG, w_XTB, a_load, a_zero, s_write;
  logic [4:0] digit;
  logic [1:0] dbg_state;
`ifdef ASU_SEQ_STEP_EN
  logic       step;
`endif

  // DIGIT_CYCLES=3 instance signals
  logic       rst3, start3;
  logic [1:0] op3;
  logic       ready3, busy3, done3, dpg3, xtb3, a_load3, a_zero3, s_write3;
  logic [4:0] digit3;
  logic [1:0] dbg_state3;

  asu_sequencer #(.WORD_BITS(32), .DIGIT_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .start(start),
`ifdef ASU_SEQ_STEP_EN
    .step(step),
`endif
    .op(op), .ready(ready), .busy(busy), .done(done), .digit(digit),
    .w_DPG(w_DPG), .w_XTB(w_XTB), .a_load(a_load), .a_zero(a_zero),
    .s_write(s_write), .dbg_state(dbg_state)
  );

  asu_sequencer #(.WORD_BITS(32), .DIGIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst3), .start(start3),
`ifdef ASU_SEQ_STEP_EN
    .step(1'b1),
`endif
    .op(op3), .ready(ready3), .busy(busy3), .done(done3), .digit(digit3),
    .w_DPG(dpg3), .w_XTB(xtb3), .a_load(a_load3), .a_zero(a_zero3),
    .s_write(s_write3), .dbg_state(dbg_state3)
  );

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [12:0] exp;
  } vec_t;

  vec_t vecs[6];

  // Output bundle: {ready, busy, done, digit[4:0], dpg, xtb, a_load, a_zero, s_write}
  function automatic logic [12:0] mk(int r, int b, int d, int dg, int p, int x,
                                     int al, int az, int sw);
    logic [4:0] dg5;
    dg5 = 5'(dg);
    return {1'(r), 1'(b), 1'(d), dg5, 1'(p), 1'(x), 1'(al), 1'(az), 1'(sw)};
  endfunction

  function automatic logic [12:0] outs();
    return {ready, busy, done, digit, w_DPG, w_XTB, a_load, a_zero, s_write};
  endfunction

  function automatic logic [12:0] outs3();
    return {ready3, busy3, done3, digit3, dpg3, xtb3, a_load3, a_zero3, s_write3};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  int dpg_cnt;

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00;
    rst3 = 1'b1; start3 = 1'b0; op3 = 2'b00;
`ifdef ASU_SEQ_STEP_EN
    step = 1'b1;
`endif
    // Vector table: inputs applied before an edge, outputs expected after it.
    vecs[0] = '{1'b1, 1'b0, 2'b00, mk(1, 0, 0, 0, 0, 0, 0, 0, 0)};  // reset
    vecs[1] = '{1'b1, 1'b1, 2'b01, mk(1, 0, 0, 0, 0, 0, 0, 0, 0)};  // rst beats start
    vecs[2] = '{1'b0, 1'b0, 2'b00, mk(1, 0, 0, 0, 0, 0, 0, 0, 0)};  // dropped request not latched
    vecs[3] = '{1'b0, 1'b1, 2'b01, mk(0, 1, 0, 0, 1, 1, 1, 1, 0)};  // LDN cycle 1
    vecs[4] = '{1'b0, 1'b1, 2'b11, mk(0, 1, 0, 1, 1, 0, 1, 1, 0)};  // start while busy ignored
    vecs[5] = '{1'b0, 1'b0, 2'b00, mk(0, 1, 0, 2, 1, 0, 1, 1, 0)};  // op change has no effect

    tick(); tick();
    rst3 = 1'b0;
    chk("reset_state", 32'(dbg_state), 32'd0);

    for (int i = 0; i < 6; i++) begin
      rst = vecs[i].rst; start = vecs[i].start; op = vecs[i].op;
      tick();
      chk($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
    end

    // LDN: remaining RUN cycles 4..32, done at 33, ready at 34
    for (int c = 4; c <= 32; c++) begin
      tick();
      chk($sformatf("ldn_c%0d", c), 32'(outs()), 32'(mk(0, 1, 0, c - 1, 1, 0, 1, 1, 0)));
    end
    tick();
    chk("ldn_done", 32'(outs()), 32'(mk(0, 0, 1, 0, 0, 0, 0, 0, 0)));
    tick();
    chk("ldn_ready", 32'(outs()), 32'(mk(1, 0, 0, 0, 0, 0, 0, 0, 0)));

    // STO, then SUB requested continuously from cycle 1
    start = 1'b1; op = 2'b11;
    tick();
    op = 2'b10;
    for (int c = 1; c <= 32; c++) begin
      chk($sformatf("sto_c%0d", c), 32'(outs()), 32'(mk(0, 1, 0, c - 1, 1, c == 1, 0, 0, 1)));
      tick();
    end
    chk("sto_done", 32'(outs()), 32'(mk(0, 0, 1, 0, 0, 0, 0, 0, 0)));
    tick();
    chk("sto_ready", 32'(outs()), 32'(mk(1, 0, 0, 0, 0, 0, 0, 0, 0)));
    tick();
    start = 1'b0;
    chk("sub_first", 32'(outs()), 32'(mk(0, 1, 0, 0, 1, 1, 1, 0, 0)));
    repeat (10) tick();
    chk("sub_digit10", 32'(outs()), 32'(mk(0, 1, 0, 10, 1, 0, 1, 0, 0)));

    // Reset in the middle of SUB
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_outs", 32'(outs()), 32'(mk(1, 0, 0, 0, 0, 0, 0, 0, 0)));
    chk("midrst_state", 32'(dbg_state), 32'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("midrst_idle%0d", c), 32'(outs()), 32'(mk(1, 0, 0, 0, 0, 0, 0, 0, 0)));
    end

    // DIGIT_CYCLES=3, NOP
    start3 = 1'b1; op3 = 2'b00;
    tick();
    start3 = 1'b0;
    dpg_cnt = 0;
    for (int c = 1; c <= 96; c++) begin
      chk($sformatf("nop3_c%0d", c), 32'(outs3()),
          32'(mk(0, 1, 0, (c - 1) / 3, ((c - 1) % 3) == 0, c == 1, 0, 0, 0)));
      if (dpg3) dpg_cnt++;
      tick();
    end
    chk("nop3_done", 32'(outs3()), 32'(mk(0, 0, 1, 0, 0, 0, 0, 0, 0)));
    chk("nop3_dpg_count", 32'(dpg_cnt), 32'd32);
    tick();
    chk("nop3_ready", 32'(outs3()), 32'(mk(1, 0, 0, 0, 0, 0, 0, 0, 0)));

`ifdef ASU_SEQ_STEP_EN
    // Single step: LDN with step pulsed every 4th cycle
    start = 1'b1; op = 2'b01; step = 1'b0;
    tick();
    start = 1'b0;
    #1;
    for (int i = 0; i < 32; i++) begin
      repeat (3) begin
        chk($sformatf("step_hold%0d", i), 32'(outs()), 32'(mk(0, 1, 0, i, 0, 0, 1, 1, 0)));
        tick();
      end
      step = 1'b1;
      #1;
      chk($sformatf("step_pulse%0d", i), 32'(outs()), 32'(mk(0, 1, 0, i, 1, i == 0, 1, 1, 0)));
      tick();
      step = 1'b0;
      #1;
    end
    chk("step_done", 32'(outs()), 32'(mk(0, 0, 1, 0, 0, 0, 0, 0, 0)));
    step = 1'b1;
    tick();
    chk("step_ready", 32'(outs()), 32'(mk(1, 0, 0, 0, 0, 0, 0, 0, 0)));
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
